// File: rtl/lzs_pkg.sv
// ============================================================================
// Module      : lzs_pkg
// Description : Shared states, code widths and length-code table for the LZS packer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lzs_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_TOKEN = 3'd1,
        S_LEN1  = 3'd2,
        S_LENX  = 3'd3,
        S_PAD   = 3'd4,
        S_FLUSH = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    localparam logic [3:0] LIT_W      = 4'd9;
    localparam logic [3:0] OFF7_W     = 4'd9;
    localparam logic [3:0] OFF11_W    = 4'd13;
    localparam logic [3:0] NIBBLE_W   = 4'd4;
    localparam logic [8:0] END_CODE   = 9'b110000000;
    localparam logic [3:0] NIBBLE_ESC = 4'hF;

    typedef struct packed {
        logic [3:0] code;
        logic [3:0] w;
    } len_code_t;

    // Short length codes for match lengths 2..7.
    function automatic len_code_t short_len_code(input logic [2:0] len);
        len_code_t r;
        case (len)
            3'd2:    r = '{code: 4'b0000, w: 4'd2};
            3'd3:    r = '{code: 4'b0001, w: 4'd2};
            3'd4:    r = '{code: 4'b0010, w: 4'd2};
            3'd5:    r = '{code: 4'b1100, w: 4'd4};
            3'd6:    r = '{code: 4'b1101, w: 4'd4};
            3'd7:    r = '{code: 4'b1110, w: 4'd4};
            default: r = '{code: 4'b0000, w: 4'd0};
        endcase
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lzs_bit_packer.sv
// ============================================================================
// Module      : lzs_bit_packer
// Description : MSB-first bit accumulator; accepts one code per cycle, drains bytes to FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lzs_bit_packer #(
    parameter int ACC_W = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push_req,
    input  logic [12:0] push_code,
    input  logic [3:0]  push_w,
    output logic        push_ok,
    input  logic        fo_full,
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic [2:0]  cnt_mod8,
    output logic        cnt_zero
);

    localparam int CNT_W = $clog2(ACC_W + 1);

    logic [ACC_W-1:0] acc_q, acc_d, acc_base;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_base, shamt;
    logic [7:0]       out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             drain, push_en;

    always_comb begin
        drain    = (cnt_q >= CNT_W'(8)) && !fo_full;
        // Fit is judged on the pre-drain count so it never depends on fo_full.
        push_ok  = ({1'b0, cnt_q} + (CNT_W+1)'(push_w)) <= (CNT_W+1)'(ACC_W);
        push_en  = push_req && push_ok;
        acc_base = drain ? (acc_q << 8) : acc_q;
        cnt_base = drain ? (cnt_q - CNT_W'(8)) : cnt_q;
        shamt    = CNT_W'(ACC_W) - cnt_base - CNT_W'(push_w);
        acc_d    = acc_base;
        cnt_d    = cnt_base;
        if (push_en) begin
            acc_d = acc_base | (ACC_W'(push_code) << shamt);
            cnt_d = cnt_base + CNT_W'(push_w);
        end
        out_valid_d = drain;
        out_data_d  = drain ? acc_q[ACC_W-1 -: 8] : out_data_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign cnt_mod8  = cnt_q[2:0];
    assign cnt_zero  = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/lzs_encode_pack.sv
// ============================================================================
// Module      : lzs_encode_pack
// Description : LZS token-to-bitstream encoder FSM. Optional LZS_PACK_STAT_EN adds byte_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lzs_encode_pack
    import lzs_pkg::*;
#(
    parameter int LEN_W = 11,
    parameter int ACC_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce_encode,
    input  logic             token_valid,
    input  logic             token_match,
    input  logic             token_end,
    input  logic [7:0]       token_lit,
    input  logic [10:0]      token_off,
    input  logic [LEN_W-1:0] token_len,
    output logic             token_ack,
    input  logic             fo_full,
    output logic [7:0]       out_data,
    output logic             out_valid,
    output logic             all_end
`ifdef LZS_PACK_STAT_EN
    ,
    output logic [31:0]      byte_cnt
`endif
);

    state_t           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d, rem_q, rem_d;
    logic             push_req, push_ok, cnt_zero;
    logic [12:0]      push_code;
    logic [3:0]       push_w;
    logic [2:0]       cnt_mod8;
    len_code_t        short_code;

    lzs_bit_packer #(.ACC_W(ACC_W)) u_packer (
        .clk       (clk),
        .rst       (rst),
        .push_req  (push_req),
        .push_code (push_code),
        .push_w    (push_w),
        .push_ok   (push_ok),
        .fo_full   (fo_full),
        .out_data  (out_data),
        .out_valid (out_valid),
        .cnt_mod8  (cnt_mod8),
        .cnt_zero  (cnt_zero)
    );

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        rem_d      = rem_q;
        push_req   = 1'b0;
        push_code  = '0;
        push_w     = '0;
        token_ack  = 1'b0;
        short_code = short_len_code(len_q[2:0]);
        unique case (state_q)
            S_IDLE: if (ce_encode) state_d = S_TOKEN;
            S_TOKEN: begin
                if (token_valid) begin
                    push_req = 1'b1;
                    if (token_end) begin
                        push_code = 13'(END_CODE);
                        push_w    = LIT_W;
                        if (push_ok) state_d = S_PAD;
                    end else if (!token_match) begin
                        push_code = {5'b0, token_lit};
                        push_w    = LIT_W;
                        token_ack = push_ok;
                    end else begin
                        if (token_off < 11'd128) begin
                            push_code = 13'({2'b11, token_off[6:0]});
                            push_w    = OFF7_W;
                        end else begin
                            push_code = {2'b10, token_off};
                            push_w    = OFF11_W;
                        end
                        if (push_ok) begin
                            len_d   = token_len;
                            state_d = S_LEN1;
                        end
                    end
                end
            end
            S_LEN1: begin
                push_req = 1'b1;
                if (len_q < LEN_W'(8)) begin
                    push_code = 13'(short_code.code);
                    push_w    = short_code.w;
                    if (push_ok) begin
                        token_ack = 1'b1;
                        state_d   = S_TOKEN;
                    end
                end else begin
                    push_code = 13'(NIBBLE_ESC);
                    push_w    = NIBBLE_W;
                    if (push_ok) begin
                        rem_d   = len_q - LEN_W'(8);
                        state_d = S_LENX;
                    end
                end
            end
            S_LENX: begin
                push_req = 1'b1;
                push_w   = NIBBLE_W;
                if (rem_q >= LEN_W'(15)) begin
                    push_code = 13'(NIBBLE_ESC);
                    if (push_ok) rem_d = rem_q - LEN_W'(15);
                end else begin
                    push_code = 13'(rem_q[3:0]);
                    if (push_ok) begin
                        token_ack = 1'b1;
                        state_d   = S_TOKEN;
                    end
                end
            end
            S_PAD: begin
                // Zero bits up to the next byte boundary; a zero-width push is legal.
                push_req = 1'b1;
                push_w   = {1'b0, 3'd0 - cnt_mod8};
                if (push_ok) state_d = S_FLUSH;
            end
            S_FLUSH: if (cnt_zero) state_d = S_DONE;
            S_DONE:  if (!ce_encode) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            rem_q   <= rem_d;
        end
    end

    assign all_end = (state_q == S_DONE);

`ifdef LZS_PACK_STAT_EN
    logic [31:0] byte_cnt_q, byte_cnt_d;

    always_comb begin
        byte_cnt_d = byte_cnt_q;
        if (state_q == S_IDLE && ce_encode) begin
            byte_cnt_d = '0;
        end else if (out_valid && byte_cnt_q != '1) begin
            byte_cnt_d = byte_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) byte_cnt_q <= '0;
        else     byte_cnt_q <= byte_cnt_d;
    end

    assign byte_cnt = byte_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_lzs_encode_pack.sv
// ============================================================================
// Module      : tb_lzs_encode_pack
// Description : Directed and randomised token streams against hand values and a bit model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lzs_encode_pack;
    import lzs_pkg::*;

    logic        clk = 1'b0;
    logic        rst, ce_encode, token_valid, token_match, token_end, fo_full;
    logic [7:0]  token_lit;
    logic [10:0] token_off;
    logic [10:0] token_len;
    logic        token_ack, out_valid, all_end;
    logic [7:0]  out_data;
`ifdef LZS_PACK_STAT_EN
    logic [31:0] byte_cnt;
`endif

    int checks = 0;
    int failures = 0;
    int ack_cnt = 0;
    int ack_snap;
    logic [7:0] got[$];
    logic [7:0] hand[$];
    logic [7:0] mbytes[$];
    bit         mbits[$];
    bit         stream_done;

    lzs_encode_pack #(.LEN_W(11), .ACC_W(24)) dut (
        .clk         (clk),
        .rst         (rst),
        .ce_encode   (ce_encode),
        .token_valid (token_valid),
        .token_match (token_match),
        .token_end   (token_end),
        .token_lit   (token_lit),
        .token_off   (token_off),
        .token_len   (token_len),
        .token_ack   (token_ack),
        .fo_full     (fo_full),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .all_end     (all_end)
`ifdef LZS_PACK_STAT_EN
        ,
        .byte_cnt    (byte_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && out_valid) got.push_back(out_data);
        if (!rst && token_ack) ack_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference bitstream model built straight from the code definitions.
    task automatic m_put(input logic [12:0] v, input int w);
        for (int i = w - 1; i >= 0; i--) mbits.push_back(v[i]);
    endtask

    task automatic m_match(input int off, input int len);
        int rem;
        if (off < 128) m_put(13'(9'h180 | off), 9);
        else           m_put(13'(13'h1000 | off), 13);
        if (len <= 4)      m_put(13'(len - 2), 2);
        else if (len <= 7) m_put(13'(12 + len - 5), 4);
        else begin
            m_put(13'hF, 4);
            rem = len - 8;
            while (rem >= 15) begin m_put(13'hF, 4); rem -= 15; end
            m_put(13'(rem), 4);
        end
    endtask

    task automatic m_end();
        logic [7:0] b;
        m_put(13'h180, 9);
        while (mbits.size() % 8 != 0) mbits.push_back(1'b0);
        for (int i = 0; i < mbits.size(); i += 8) begin
            for (int j = 0; j < 8; j++) b[7-j] = mbits[i+j];
            mbytes.push_back(b);
        end
    endtask

    task automatic do_token(input string tag);
        bit seen = 1'b0;
        token_valid = 1'b1;
        for (int n = 0; n < 300 && !seen; n++) begin
            @(negedge clk);
            seen = token_ack;
        end
        if (seen) @(posedge clk);
        #1 token_valid = 1'b0;
        check({tag, "_ack"}, 32'(seen), 32'd1);
    endtask

    task automatic send_lit(input logic [7:0] b);
        m_put({5'b0, b}, 9);
        token_end = 1'b0; token_match = 1'b0; token_lit = b;
        do_token("lit");
    endtask

    task automatic send_match(input int off, input int len);
        assert (off != 0 && len >= 2) else $fatal(1, "illegal token stimulus");
        m_match(off, len);
        token_end = 1'b0; token_match = 1'b1;
        token_off = 11'(off); token_len = 11'(len);
        do_token("match");
    endtask

    task automatic start_stream();
        got.delete(); mbits.delete(); mbytes.delete();
        ack_cnt = 0;
        ce_encode = 1'b1;
    endtask

    task automatic end_stream(input string tag);
        m_end();
        token_end = 1'b1; token_valid = 1'b1;
        for (int n = 0; n < 300 && !all_end; n++) @(negedge clk);
        check({tag, "_all_end"}, 32'(all_end), 32'd1);
        token_valid = 1'b0; token_end = 1'b0;
        ce_encode = 1'b0;
        repeat (2) @(negedge clk);
        check({tag, "_all_end_clr"}, 32'(all_end), 32'd0);
    endtask

    task automatic cmp_bytes(input string tag, input bit use_hand);
        logic [7:0] r[$];
        if (use_hand) r = hand; else r = mbytes;
        check({tag, "_nbytes"}, 32'(got.size()), 32'(r.size()));
        for (int i = 0; i < r.size() && i < got.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), 32'(got[i]), 32'(r[i]));
    endtask

    initial begin
        rst = 1'b1; ce_encode = 1'b0; token_valid = 1'b0; token_match = 1'b0;
        token_end = 1'b0; token_lit = '0; token_off = '0; token_len = '0; fo_full = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ack", 32'(token_ack), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_all_end", 32'(all_end), 32'd0);
        rst = 1'b0;

        // 1: literal then end
        start_stream();
        send_lit(8'h41);
        check("t1_acks", 32'(ack_cnt), 32'd1);
        end_stream("t1");
        hand = {8'h20, 8'hE0, 8'h00};
        cmp_bytes("t1", 1'b1);

        // 2: short match
        start_stream();
        send_match(5, 2);
        check("t2_acks", 32'(ack_cnt), 32'd1);
        end_stream("t2");
        hand = {8'hC2, 8'h98, 8'h00};
        cmp_bytes("t2", 1'b1);

        // 3: long offset, len 6
        start_stream();
        send_match(300, 6);
        end_stream("t3");
        hand = {8'h89, 8'h66, 8'hE0, 8'h00};
        cmp_bytes("t3", 1'b1);
`ifdef LZS_PACK_STAT_EN
        check("t3_byte_cnt", byte_cnt, 32'd4);
`endif

        // 4: extended lengths, exact multiple of 15 and one short of it
        start_stream();
        send_match(1, 23);
        send_match(1, 22);
        check("t4_acks", 32'(ack_cnt), 32'd2);
        end_stream("t4");
        hand = {8'hC0, 8'hFF, 8'h86, 8'h07, 8'hFB, 8'h00};
        cmp_bytes("t4", 1'b1);

        // 5: FIFO full for 20 cycles mid-stream
        start_stream();
        fork
            begin
                for (int i = 0; i < 16; i++) send_lit(8'(8'h11 * i + 3));
                send_match(700, 12);
            end
            begin
                repeat (4) @(negedge clk);
                fo_full = 1'b1;
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk); #2;
                    check("t5_stall_valid", 32'(out_valid), 32'd0);
                    if (i == 9) ack_snap = ack_cnt;
                end
                check("t5_stall_noack", 32'(ack_cnt), 32'(ack_snap));
                fo_full = 1'b0;
            end
        join
        end_stream("t5");
        cmp_bytes("t5", 1'b0);

        // 6: reset while emitting extension nibbles
        start_stream();
        token_end = 1'b0; token_match = 1'b1; token_off = 11'd9; token_len = 11'd200;
        token_valid = 1'b1;
        for (int n = 0; n < 50 && dut.state_q != S_LENX; n++) @(negedge clk);
        check("t6_in_lenx", 32'(dut.state_q), 32'(S_LENX));
        rst = 1'b1;
        #1;
        check("t6_rst_ack", 32'(token_ack), 32'd0);
        check("t6_rst_valid", 32'(out_valid), 32'd0);
        check("t6_rst_data", 32'(out_data), 32'd0);
        check("t6_rst_all_end", 32'(all_end), 32'd0);
        check("t6_rst_state", 32'(dut.state_q), 32'(S_IDLE));
        token_valid = 1'b0; ce_encode = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        start_stream();
        send_lit(8'h41);
        end_stream("t6");
        hand = {8'h20, 8'hE0, 8'h00};
        cmp_bytes("t6", 1'b1);

        // Random token stream with random backpressure
        start_stream();
        stream_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(1, 0) == 0) send_lit(8'($urandom));
                    else if ($urandom_range(1, 0) == 0)
                        send_match($urandom_range(127, 1), $urandom_range(20, 2));
                    else
                        send_match($urandom_range(2047, 1), $urandom_range(300, 2));
                end
                stream_done = 1'b1;
            end
            begin
                while (!stream_done) begin
                    @(negedge clk);
                    fo_full = ($urandom_range(3, 0) == 0);
                end
                fo_full = 1'b0;
            end
        join
        check("rnd_acks", 32'(ack_cnt), 32'd300);
        end_stream("rnd");
        cmp_bytes("rnd", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
